uart_tx: RTL and testbench



---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_tx_if.sv | 11 +
 rtl/bit_timer.sv | 38 +++
 rtl/uart_tx.sv | 160 ++++++++++++++++
 tb/tb_uart_tx.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit path.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PAR,
        ST_STOP
    } state_e;

    localparam int unsigned PARITY_NONE = 0;
    localparam int unsigned PARITY_ODD  = 1;
    localparam int unsigned PARITY_EVEN = 2;

    function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                                 input int unsigned baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte-level valid/ready handshake into the UART transmitter.
interface uart_tx_if;

    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input  tx_ready);
    modport slave  (input  tx_data, input  tx_valid, output tx_ready);

endinterface

// File: rtl/bit_timer.sv
// Free-running bit-period counter with a registered end-of-bit pulse.
module bit_timer #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic bit_done
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;

    // done is registered from the next count so it is high exactly while cnt_q == LAST
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (restart || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
        done_d = (cnt_d == LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign bit_done = done_q;

endmodule

// File: rtl/uart_tx.sv
// 8-bit UART transmitter: holding register, shifter, framing FSM and registered line driver.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = 100_000_000,
    parameter int unsigned BAUD_RATE = 9600,
    parameter int unsigned PARITY    = 0,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic      clk,
    input  logic      rst,
    uart_tx_if.slave  tx,
    output logic      dout,
    output logic      busy
);

    localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);

    if (CLKS_PER_BIT < 2) begin : g_bad_cpb
        $error("uart_tx: CLK_FREQ/BAUD_RATE must be at least 2");
    end
    if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop
        $error("uart_tx: STOP_BITS must be 1 or 2");
    end
    if (PARITY > PARITY_EVEN) begin : g_bad_par
        $error("uart_tx: PARITY must be 0, 1 or 2");
    end

    state_e     state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] hold_q, hold_d;
    logic       hold_full_q, hold_full_d;
    logic [2:0] idx_q, idx_d;
    logic       stop_q, stop_d;
    logic       par_q, par_d;
    logic       dout_q, dout_d;
    logic       busy_q, busy_d;
    logic       ready_q, ready_d;
    logic       load_c, take_c, bit_done;

    bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_bit_timer (
        .clk      (clk),
        .rst      (rst),
        .restart  (load_c),
        .bit_done (bit_done)
    );

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        idx_d       = idx_q;
        stop_d      = stop_q;
        par_d       = par_q;
        load_c      = 1'b0;
        take_c      = tx.tx_valid && ready_q;
        hold_full_d = hold_full_q;
        ready_d     = ready_q;
        busy_d      = busy_q;
        dout_d      = 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (hold_full_q) begin
                    state_d = ST_START;
                    load_c  = 1'b1;
                end
            end
            ST_START: begin
                if (bit_done) begin
                    state_d = ST_DATA;
                    idx_d   = '0;
                end
            end
            ST_DATA: begin
                if (bit_done) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    if (idx_q == 3'd7) begin
                        state_d = (PARITY != PARITY_NONE) ? ST_PAR : ST_STOP;
                        stop_d  = 1'b0;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            ST_PAR: begin
                if (bit_done) begin
                    state_d = ST_STOP;
                    stop_d  = 1'b0;
                end
            end
            ST_STOP: begin
                if (bit_done) begin
                    if ((STOP_BITS == 1) || stop_q) begin
                        if (hold_full_q) begin
                            state_d = ST_START;
                            load_c  = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        stop_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Parity is fixed at load time from the byte entering the shifter
        if (load_c) begin
            shift_d = hold_q;
            par_d   = (^hold_q) ^ (PARITY == PARITY_ODD);
        end

        hold_full_d = (hold_full_q && !load_c) || take_c;
        if (take_c) begin
            hold_d = tx.tx_data;
        end
        ready_d = !hold_full_d;
        busy_d  = (state_d != ST_IDLE);

        case (state_d)
            ST_START: dout_d = 1'b0;
            ST_DATA:  dout_d = shift_d[0];
            ST_PAR:   dout_d = par_d;
            default:  dout_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            shift_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            idx_q       <= '0;
            stop_q      <= 1'b0;
            par_q       <= 1'b0;
            dout_q      <= 1'b1;
            busy_q      <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            idx_q       <= idx_d;
            stop_q      <= stop_d;
            par_q       <= par_d;
            dout_q      <= dout_d;
            busy_q      <= busy_d;
            ready_q     <= ready_d;
        end
    end

    assign tx.tx_ready = ready_q;
    assign dout        = dout_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx across parity and stop-bit configurations.
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data;
    logic       valid;
    logic [1:0] sel;
    int         checks = 0;
    int         errors = 0;

    logic [3:0] dout_w, busy_w;
    logic       dout_s, busy_s, ready_s;

    uart_tx_if if0 ();
    uart_tx_if if1 ();
    uart_tx_if if2 ();
    uart_tx_if if3 ();

    assign if0.tx_data  = data;
    assign if1.tx_data  = data;
    assign if2.tx_data  = data;
    assign if3.tx_data  = data;
    assign if0.tx_valid = valid && (sel == 2'd0);
    assign if1.tx_valid = valid && (sel == 2'd1);
    assign if2.tx_valid = valid && (sel == 2'd2);
    assign if3.tx_valid = valid && (sel == 2'd3);

    uart_tx #(.CLK_FREQ(16), .BAUD_RATE(1), .PARITY(0), .STOP_BITS(1)) u_dut0 (
        .clk(clk), .rst(rst), .tx(if0), .dout(dout_w[0]), .busy(busy_w[0]));
    uart_tx #(.CLK_FREQ(16), .BAUD_RATE(1), .PARITY(2), .STOP_BITS(1)) u_dut1 (
        .clk(clk), .rst(rst), .tx(if1), .dout(dout_w[1]), .busy(busy_w[1]));
    uart_tx #(.CLK_FREQ(16), .BAUD_RATE(1), .PARITY(1), .STOP_BITS(1)) u_dut2 (
        .clk(clk), .rst(rst), .tx(if2), .dout(dout_w[2]), .busy(busy_w[2]));
    uart_tx #(.CLK_FREQ(16), .BAUD_RATE(1), .PARITY(0), .STOP_BITS(2)) u_dut3 (
        .clk(clk), .rst(rst), .tx(if3), .dout(dout_w[3]), .busy(busy_w[3]));

    always #5 clk = ~clk;

    always_comb begin
        dout_s = dout_w[sel];
        busy_s = busy_w[sel];
        case (sel)
            2'd0:    ready_s = if0.tx_ready;
            2'd1:    ready_s = if1.tx_ready;
            2'd2:    ready_s = if2.tx_ready;
            default: ready_s = if3.tx_ready;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present a byte, wait (bounded) for ready, leave at the negedge after the transfer edge
    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk);
        data  = b;
        valid = 1'b1;
        while (!ready_s && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("send_timeout", 32'(n < 1000), 32'd1);
        @(negedge clk);
        valid = 1'b0;
    endtask

    // Called at the first negedge of the start bit; checks every cycle of every bit
    task automatic check_frame(input string tag, input logic [7:0] b, input int par_bit,
                               input int stops, input int drop_at, output logic rdy_seen);
        logic exp_bits[12];
        int   nb;
        int   cyc;
        exp_bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) exp_bits[1+i] = b[i];
        nb = 9;
        if (par_bit >= 0) begin
            exp_bits[nb] = par_bit[0];
            nb++;
        end
        for (int s = 0; s < stops; s++) begin
            exp_bits[nb] = 1'b1;
            nb++;
        end
        rdy_seen = 1'b0;
        cyc = 0;
        for (int i = 0; i < nb; i++) begin
            logic obs, bobs;
            obs  = exp_bits[i];
            bobs = 1'b1;
            for (int c = 0; c < 16; c++) begin
                if (dout_s !== exp_bits[i]) obs = dout_s;
                if (busy_s !== 1'b1) bobs = busy_s;
                if (cyc >= 1 && ready_s === 1'b1) rdy_seen = 1'b1;
                @(negedge clk);
                cyc++;
                if (cyc == drop_at) valid = 1'b0;
            end
            chk($sformatf("%s_bit%0d", tag, i), 32'(obs), 32'(exp_bits[i]));
            chk($sformatf("%s_busy%0d", tag, i), 32'(bobs), 32'd1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic rs, bad_d, bad_b, bad_r;
        rst   = 1'b1;
        valid = 1'b0;
        data  = 8'h00;
        sel   = 2'd0;
        repeat (3) @(negedge clk);
        chk("rst_dout_all", 32'(dout_w), 32'hF);
        chk("rst_busy_all", 32'(busy_w), 32'h0);
        chk("rst_ready", 32'(ready_s), 32'd1);
        rst = 1'b0;

        // idle stability
        bad_d = 1'b0; bad_b = 1'b0; bad_r = 1'b0;
        repeat (50) begin
            @(negedge clk);
            if (dout_s !== 1'b1) bad_d = 1'b1;
            if (busy_s !== 1'b0) bad_b = 1'b1;
            if (ready_s !== 1'b1) bad_r = 1'b1;
        end
        chk("idle_dout", 32'(bad_d), 32'd0);
        chk("idle_busy", 32'(bad_b), 32'd0);
        chk("idle_ready", 32'(bad_r), 32'd0);

        // single frame 0x55
        send(8'h55);
        chk("t2_ready_low", 32'(ready_s), 32'd0);
        chk("t2_busy_pre", 32'(busy_s), 32'd0);
        chk("t2_dout_pre", 32'(dout_s), 32'd1);
        @(negedge clk);
        check_frame("t2", 8'h55, -1, 1, 0, rs);
        chk("t2_ready_seen", 32'(rs), 32'd1);
        chk("t2_busy_end", 32'(busy_s), 32'd0);
        chk("t2_dout_end", 32'(dout_s), 32'd1);

        // back-to-back 0xA5, 0x3C
        send(8'hA5);
        data  = 8'h3C;
        valid = 1'b1;
        @(negedge clk);
        check_frame("t3a", 8'hA5, -1, 1, 1, rs);
        chk("t3_ready_held_low", 32'(rs), 32'd0);
        chk("t3_ready_reload", 32'(ready_s), 32'd1);
        check_frame("t3b", 8'h3C, -1, 1, 0, rs);
        chk("t3_busy_end", 32'(busy_s), 32'd0);

        // even parity
        sel = 2'd1;
        send(8'h07);
        @(negedge clk);
        check_frame("t4e", 8'h07, 1, 1, 0, rs);
        chk("t4e_busy_end", 32'(busy_s), 32'd0);

        // odd parity
        sel = 2'd2;
        send(8'h07);
        @(negedge clk);
        check_frame("t4o", 8'h07, 0, 1, 0, rs);
        chk("t4o_busy_end", 32'(busy_s), 32'd0);

        // two stop bits
        sel = 2'd3;
        send(8'hFF);
        @(negedge clk);
        check_frame("t5", 8'hFF, -1, 2, 0, rs);
        chk("t5_busy_end", 32'(busy_s), 32'd0);

        // reset in data bit 3 with a pending byte
        sel = 2'd0;
        send(8'h00);
        send(8'hEE);
        repeat (70) @(negedge clk);
        chk("t6_pending", 32'(ready_s), 32'd0);
        chk("t6_dbit3", 32'(dout_s), 32'd0);
        rst = 1'b1;
        #1;
        chk("t6_rst_dout", 32'(dout_s), 32'd1);
        chk("t6_rst_ready", 32'(ready_s), 32'd1);
        chk("t6_rst_busy", 32'(busy_s), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bad_d = 1'b0; bad_b = 1'b0;
        repeat (200) begin
            @(negedge clk);
            if (dout_s !== 1'b1) bad_d = 1'b1;
            if (busy_s !== 1'b0) bad_b = 1'b1;
        end
        chk("t6_no_pending_dout", 32'(bad_d), 32'd0);
        chk("t6_no_pending_busy", 32'(bad_b), 32'd0);
        send(8'h81);
        @(negedge clk);
        check_frame("t6", 8'h81, -1, 1, 0, rs);
        chk("t6_busy_end", 32'(busy_s), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
